// File: rtl/timer_with_clock_alarm_out.sv
`default_nettype none
// ============================================================================
// timer_with_clock_alarm_out : Avalon-MM LED/buzzer output port with SET and
// CLEAR aliases and an optional cycle-exact pulse channel (ALARM_PULSE_EN).
// Revision: 1.0
// ============================================================================
module timer_with_clock_alarm_out #(
    parameter int unsigned      WIDTH       = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    localparam logic [1:0] c_ADDR_DATA  = 2'd0;
    localparam logic [1:0] c_ADDR_SET   = 2'd1;
    localparam logic [1:0] c_ADDR_CLEAR = 2'd2;
    localparam logic [1:0] c_ADDR_PULSE = 2'd3;

    logic             w_wr;
    logic [WIDTH-1:0] w_wmask;
    logic [WIDTH-1:0] data_q, data_d;
    logic [31:0]      readdata_q, readdata_d;
    logic [WIDTH-1:0] w_pulse_bits;
    logic [31:0]      w_pulse_rd;
    logic             w_unused_bits;

    assign w_wr          = chipselect & ~write_n;
    assign w_wmask       = writedata[WIDTH-1:0];
    assign w_unused_bits = ^writedata;

    always_comb begin
        data_d = data_q;
        if (w_wr) begin
            case (address)
                c_ADDR_DATA:  data_d = w_wmask;
                c_ADDR_SET:   data_d = data_q | w_wmask;
                c_ADDR_CLEAR: data_d = data_q & ~w_wmask;
                default:      data_d = data_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= RESET_VALUE;
        end else begin
            data_q <= data_d;
        end
    end

`ifdef ALARM_PULSE_EN
    logic [WIDTH-1:0] pmask_q, pmask_d;
    logic [15:0]      pcnt_q, pcnt_d;

    // A PULSE write always wins over the countdown, so a reload or a
    // zero-length cancel takes effect on the very next edge.
    always_comb begin
        pmask_d = pmask_q;
        pcnt_d  = pcnt_q;
        if (w_wr && (address == c_ADDR_PULSE)) begin
            pmask_d = w_wmask;
            pcnt_d  = writedata[31:16];
        end else if (pcnt_q != 16'd0) begin
            pcnt_d = pcnt_q - 16'd1;
            if (pcnt_q == 16'd1) begin
                pmask_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pmask_q <= '0;
            pcnt_q  <= 16'd0;
        end else begin
            pmask_q <= pmask_d;
            pcnt_q  <= pcnt_d;
        end
    end

    assign w_pulse_bits = (pcnt_q != 16'd0) ? pmask_q : '0;

    always_comb begin
        w_pulse_rd              = 32'd0;
        w_pulse_rd[31:16]       = pcnt_q;
        w_pulse_rd[WIDTH-1:0]   = pmask_q;
    end
`else
    assign w_pulse_bits = '0;
    assign w_pulse_rd   = 32'd0;
`endif

    assign out_port = data_q | w_pulse_bits;

    always_comb begin
        readdata_d = 32'd0;
        case (address)
            c_ADDR_DATA:  readdata_d[WIDTH-1:0] = data_q;
            c_ADDR_SET:   readdata_d[WIDTH-1:0] = out_port;
            c_ADDR_CLEAR: readdata_d            = 32'd0;
            default:      readdata_d            = w_pulse_rd;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata_q <= 32'd0;
        end else begin
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;

endmodule
`default_nettype wire

// File: tb/tb_timer_with_clock_alarm_out.sv
`default_nettype none
// ============================================================================
// tb_timer_with_clock_alarm_out : randomized and directed bench for the alarm
// output port, checked against a cycle-indexed behavioural model.
// Revision: 1.0
// ============================================================================
module tb_timer_with_clock_alarm_out;

    localparam int unsigned c_WIDTH = 4;
    localparam logic [3:0]  c_RST   = 4'h5;

    logic        clk;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [3:0]  out_port;

    int n_vec;
    int n_err;

    // Model: the pulse is described by the absolute cycle it ends on,
    // rather than by a down-counter.
    int         m_cyc;
    int         m_end;
    logic [3:0] m_data;
    logic [3:0] m_pm;
    logic       m_len0;
    logic [31:0] m_rd;

    timer_with_clock_alarm_out #(
        .WIDTH       (c_WIDTH),
        .RESET_VALUE (c_RST)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int remaining();
`ifdef ALARM_PULSE_EN
        return (m_end > m_cyc) ? (m_end - m_cyc) : 0;
`else
        return 0;
`endif
    endfunction

    function automatic logic [3:0] exp_out();
        return m_data | ((remaining() > 0) ? m_pm : 4'h0);
    endfunction

    function automatic logic [31:0] exp_rd(input logic [1:0] a);
        logic [31:0] r;
        logic [15:0] cnt;
        int          rem;
        r   = 32'd0;
        rem = remaining();
        cnt = rem[15:0];
        case (a)
            2'd0: r[3:0] = m_data;
            2'd1: r[3:0] = exp_out();
            2'd2: r = 32'd0;
            default: begin
`ifdef ALARM_PULSE_EN
                r[31:16] = cnt;
                r[3:0]   = (m_len0 || rem > 0) ? m_pm : 4'h0;
`else
                r = 32'd0;
`endif
            end
        endcase
        return r;
    endfunction

    function automatic void model_reset();
        m_data = c_RST;
        m_end  = m_cyc;
        m_pm   = 4'h0;
        m_len0 = 1'b0;
        m_rd   = 32'd0;
    endfunction

    task automatic step(input logic [1:0] a, input logic cs, input logic wn,
                        input logic [31:0] wd);
        logic [3:0] wm;
        address    = a;
        chipselect = cs;
        write_n    = wn;
        writedata  = wd;
        wm         = wd[3:0];
        @(posedge clk);
        m_rd  = exp_rd(a);
        m_cyc = m_cyc + 1;
        if (cs && !wn) begin
            case (a)
                2'd0: m_data = wm;
                2'd1: m_data = m_data | wm;
                2'd2: m_data = m_data & ~wm;
                default: begin
`ifdef ALARM_PULSE_EN
                    m_pm   = wm;
                    m_end  = m_cyc + int'(wd[31:16]);
                    m_len0 = (wd[31:16] == 16'd0);
`endif
                end
            endcase
        end
        #1;
    endtask

    task automatic test_reset();
        n_vec++;
        if (out_port !== c_RST || readdata !== 32'd0) begin
            n_err++;
            $display("FAIL reset_init: out_port=%h readdata=%h required out_port=%h readdata=0",
                     out_port, readdata, c_RST);
        end
        step(2'd0, 1'b1, 1'b0, 32'h0000_000A);
        step(2'd3, 1'b1, 1'b0, 32'h0014_000F);
        step(2'd3, 1'b0, 1'b1, 32'h0);
        step(2'd3, 1'b0, 1'b1, 32'h0);
        #2 reset = 1'b1;
        #1;
        model_reset();
        n_vec++;
        if (out_port !== c_RST || readdata !== 32'd0) begin
            n_err++;
            $display("FAIL reset_async: out_port=%h readdata=%h required out_port=%h readdata=0",
                     out_port, readdata, c_RST);
        end
        #2 reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(2'(3 - i), 1'b0, 1'b1, 32'h0);
            n_vec++;
            if (out_port !== exp_out() || readdata !== m_rd) begin
                n_err++;
                $display("FAIL reset_after[%0d]: out_port=%h readdata=%h required %h %h",
                         i, out_port, readdata, exp_out(), m_rd);
            end
        end
    endtask

    task automatic test_data_set_clear();
        logic [1:0]  a  [4] = '{2'd0, 2'd1, 2'd2, 2'd0};
        logic        wn [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [31:0] wd [4] = '{32'hFFFF_FF0A, 32'h0000_0001, 32'hABCD_0008, 32'h0};
        for (int i = 0; i < 4; i++) begin
            step(a[i], 1'b1, wn[i], wd[i]);
            n_vec++;
            if (out_port !== exp_out() || readdata !== m_rd) begin
                n_err++;
                $display("FAIL dsc[%0d]: out_port=%h readdata=%h required %h %h",
                         i, out_port, readdata, exp_out(), m_rd);
            end
        end
        step(2'd0, 1'b0, 1'b1, 32'h0);
        n_vec++;
        if (readdata !== 32'h3 || out_port !== 4'h3) begin
            n_err++;
            $display("FAIL dsc_readback: readdata=%h out_port=%h required 00000003 3",
                     readdata, out_port);
        end
    endtask

    task automatic test_pulse();
        step(2'd0, 1'b1, 1'b0, 32'h0);
        step(2'd3, 1'b1, 1'b0, 32'h0003_0004);
        for (int i = 0; i < 6; i++) begin
            step(2'd3, 1'b0, 1'b1, 32'h0);
            n_vec++;
            if (out_port !== exp_out() || readdata !== m_rd) begin
                n_err++;
                $display("FAIL pulse[%0d]: out_port=%h readdata=%h required %h %h",
                         i, out_port, readdata, exp_out(), m_rd);
            end
        end
    endtask

    task automatic test_reload_cancel();
        step(2'd3, 1'b1, 1'b0, 32'h000A_0002);
        for (int i = 0; i < 4; i++) step(2'd3, 1'b0, 1'b1, 32'h0);
        step(2'd3, 1'b1, 1'b0, 32'h0002_0008);
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (out_port !== exp_out() || readdata !== m_rd) begin
                n_err++;
                $display("FAIL reload[%0d]: out_port=%h readdata=%h required %h %h",
                         i, out_port, readdata, exp_out(), m_rd);
            end
            step(2'd3, 1'b0, 1'b1, 32'h0);
        end
        step(2'd3, 1'b1, 1'b0, 32'h0008_0006);
        step(2'd3, 1'b0, 1'b1, 32'h0);
        step(2'd3, 1'b1, 1'b0, 32'h0000_0006);
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (out_port !== exp_out() || readdata !== m_rd) begin
                n_err++;
                $display("FAIL cancel[%0d]: out_port=%h readdata=%h required %h %h",
                         i, out_port, readdata, exp_out(), m_rd);
            end
            step(2'd3, 1'b0, 1'b1, 32'h0);
        end
    endtask

    task automatic test_overlap();
        logic [1:0]  a  [10] = '{2'd0, 2'd3, 2'd1, 2'd1, 2'd1, 2'd1,
                                 2'd3, 2'd2, 2'd1, 2'd1};
        logic        wn [10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1,
                                 1'b0, 1'b0, 1'b1, 1'b1};
        logic [31:0] wd [10] = '{32'h4, 32'h0003_0004, 32'h0, 32'h0, 32'h0, 32'h0,
                                 32'h0004_0004, 32'h4, 32'h0, 32'h0};
        for (int i = 0; i < 10; i++) begin
            step(a[i], 1'b1, wn[i], wd[i]);
            n_vec++;
            if (out_port !== exp_out() || readdata !== m_rd) begin
                n_err++;
                $display("FAIL overlap[%0d]: out_port=%h readdata=%h required %h %h",
                         i, out_port, readdata, exp_out(), m_rd);
            end
        end
        for (int i = 0; i < 3; i++) begin
            step(2'd1, 1'b0, 1'b1, 32'h0);
            n_vec++;
            if (out_port !== exp_out() || readdata !== m_rd) begin
                n_err++;
                $display("FAIL overlap_tail[%0d]: out_port=%h readdata=%h required %h %h",
                         i, out_port, readdata, exp_out(), m_rd);
            end
        end
    endtask

    task automatic test_full_pulse_write();
        step(2'd0, 1'b1, 1'b0, 32'h0000_0009);
        step(2'd3, 1'b1, 1'b0, 32'hFFFF_000F);
        for (int i = 0; i < 3; i++) begin
            step(2'd3, 1'b0, 1'b1, 32'h0);
            n_vec++;
            if (out_port !== exp_out() || readdata !== m_rd) begin
                n_err++;
                $display("FAIL pulse_full[%0d]: out_port=%h readdata=%h required %h %h",
                         i, out_port, readdata, exp_out(), m_rd);
            end
        end
        step(2'd3, 1'b1, 1'b0, 32'h0);
    endtask

    task automatic test_random();
        logic [1:0]  a;
        logic        cs;
        logic        wn;
        logic [31:0] wd;
        for (int i = 0; i < 400; i++) begin
            a  = 2'($urandom_range(0, 3));
            cs = ($urandom_range(0, 3) != 0);
            wn = ($urandom_range(0, 2) == 0);
            wd = $urandom;
            if (a == 2'd3) wd[31:16] = 16'($urandom_range(0, 6));
            step(a, cs, wn, wd);
            n_vec++;
            if (out_port !== exp_out() || readdata !== m_rd) begin
                n_err++;
                $display("FAIL random[%0d]: out_port=%h readdata=%h required %h %h",
                         i, out_port, readdata, exp_out(), m_rd);
            end
        end
    endtask

    initial begin
        n_vec      = 0;
        n_err      = 0;
        m_cyc      = 0;
        reset      = 1'b1;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'd0;
        model_reset();
        #12 reset = 1'b0;
        test_reset();
        test_data_set_clear();
        test_pulse();
        test_reload_cancel();
        test_overlap();
        test_full_pulse_write();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/timer_with_clock_alarm_out.md
# timer_with_clock_alarm_out

Avalon-MM slave output port for the alarm-clock system. The CPU uses it to drive the LEDs and buzzer lines, which makes it the write-side counterpart of the button input port. It holds a data register with atomic bit-set and bit-clear aliases, plus a hardware-timed pulse channel. The pulse channel asserts chosen bits for an exact number of clock cycles, so the CPU does not have to time buzzer chirps in software.

## Interface
- WIDTH, 4: width of out_port and of every register mask field (1..16).
- RESET_VALUE, 0: value loaded into the data register on reset.
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- address  input  2  register select: 0 DATA, 1 SET, 2 CLEAR, 3 PULSE.
- chipselect  input  1  slave select.
- write_n  input  1  active-low write strobe; a write occurs when chipselect=1 and write_n=0.
- writedata  input  32  write data.
- readdata  output  32  registered read data.
- out_port  output  WIDTH  driven output lines.

## Operation
- State:
  - data[WIDTH-1:0];
  - pmask[WIDTH-1:0], the pulse mask;
  - pcnt[15:0], the pulse down-counter;
  - readdata[31:0].
- out_port = data | (pcnt != 0 ? pmask : 0). This is combinational from registers only and has no path from the bus inputs.
- Writes (one address per cycle, so SET and CLEAR can never conflict):
  - DATA: data <= writedata[WIDTH-1:0].
  - SET: data <= data | writedata[WIDTH-1:0].
  - CLEAR: data <= data & ~writedata[WIDTH-1:0].
  - PULSE: pmask <= writedata[WIDTH-1:0] and pcnt <= writedata[31:16]. A write while a pulse is active reloads both fields immediately. A length of 0 cancels the active pulse.
- Pulse countdown, on any cycle with no PULSE write:
  - if pcnt != 0, then pcnt <= pcnt - 1;
  - when pcnt goes 1 -> 0, pmask <= 0 in the same edge.
  - There is no wrap: pcnt stays at 0.
- Writes to DATA, SET or CLEAR during a pulse change data only. They do not affect the pulse.
- Read mux, evaluated every cycle regardless of chipselect (reads have no side effects):
  - address 0: {zero-extended, data};
  - address 1: {zero-extended, out_port};
  - address 2: 0;
  - address 3: {pcnt, zero-fill, pmask}.
- Unused writedata bits are ignored. Unused readdata bits read 0.

## Timing
- Reset values, applied asynchronously while reset=1:
  - data = RESET_VALUE;
  - pmask = 0 and pcnt = 0;
  - readdata = 0;
  - out_port = RESET_VALUE.
- A reset asserted mid-pulse kills the pulse immediately.
- Write latency: a write sampled at edge k is visible on out_port after edge k.
- Pulse length: a PULSE write of length L sampled at edge k asserts the mask bits for exactly L clock cycles, from after edge k until edge k+L.
- Read latency is 1 cycle: readdata after edge k reflects address and state as sampled at edge k. This is a fixed 1-wait-state read with no waitrequest.
- Write and readback in the same cycle: readdata shows the pre-write value. The new value appears one cycle later.

## Configuration
- ALARM_PULSE_EN defined:
  - pulse channel present, as described above.
- ALARM_PULSE_EN undefined:
  - pmask and pcnt are not built;
  - PULSE writes are ignored and address 3 reads 0;
  - out_port = data.
- The data register and the SET/CLEAR aliases are identical in both builds.

## Test plan
- Reset: hold reset=1 mid-run with RESET_VALUE=4'h5 -> out_port=4'h5, readdata=0, pcnt=0 asynchronously, before any clock edge.
- DATA/SET/CLEAR:
  - write DATA=4'hA -> out_port=4'hA;
  - then SET 4'h1 -> out_port=4'hB;
  - then CLEAR 4'h8 -> out_port=4'h3;
  - then read address 0 -> readdata=32'h3 one cycle after the address is sampled.
- Pulse:
  - with data=0, write PULSE writedata=32'h0003_0004 -> out_port=4'h4 for exactly 3 cycles, then 0;
  - address 3 reads show pcnt counting 3, 2, 1, 0;
  - pmask reads 0 once pcnt reaches 0.
- Pulse reload and cancel:
  - start pulse length 10 with mask 4'h2, and after 4 cycles write length 2 with mask 4'h8 -> out_port switches to 4'h8 for 2 cycles, then 0;
  - a separate run writing length 0 mid-pulse -> out_port drops on the next cycle.
- Overlap: data=4'h4 while a pulse with mask 4'h4 is active -> out_port stays 4'h4 after the pulse expires. A CLEAR 4'h4 during the pulse keeps the bit high until pcnt reaches 0.
- Build without ALARM_PULSE_EN: PULSE write 32'hFFFF_000F -> out_port unchanged and address 3 reads 0.
